// File: rtl/fifo_mon_pkg.sv
// Shared types and defaults for the FIFO underrun monitor.
package fifo_mon_pkg;

   localparam int DEFAULT_CW = 32;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter
   import fifo_mon_pkg::*;
#(
   parameter int CW = DEFAULT_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] count
);

   logic [CW-1:0] count_next;

   // NOTE: always_comb assigns a default first so no path leaves count_next unassigned (no latch).
   always_comb begin
      count_next = count;
      if (clr)
         count_next = '0;
      else if (inc && (count != '1))
         count_next = count + CW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else
         count <= count_next;
   end

endmodule

// File: rtl/fifo_underrun_mon.sv
// Passive monitor for FIFO read-side starvation inside packets.
// Define FIFO_UNDERRUN_MON_GAP_STATS_EN to build in longest-gap (max_gap) tracking.
module fifo_underrun_mon
   import fifo_mon_pkg::*;
#(
   parameter int DW = 512,
   parameter int CW = DEFAULT_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stream_tvalid,
   input  logic          stream_tready,
   input  logic [DW-1:0] stream_tdata,
   input  logic          stream_tlast,
   input  logic          clear,
   output logic          in_packet,
   output logic          underrun,
   output logic [CW-1:0] underrun_count,
   output logic [CW-1:0] beat_count,
   output logic [CW-1:0] max_gap
);

   state_t state;
   logic   beat;
   logic   starved;
   logic   prev_starved;

   // Data is observed only for interface completeness; it never influences the statistics.
   logic tdata_unused;
   assign tdata_unused = ^stream_tdata;

   assign beat    = stream_tvalid & stream_tready;
   assign starved = (state == IN_PKT) & stream_tready & ~stream_tvalid;

   // prev_starved tracks the stream itself, so clear does not split an ongoing gap into two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         in_packet    <= 1'b0;
         underrun     <= 1'b0;
         prev_starved <= 1'b0;
      end else begin
         if (beat) begin
            state     <= stream_tlast ? IDLE : IN_PKT;
            in_packet <= ~stream_tlast;
         end
         underrun     <= clear ? 1'b0 : (underrun | starved);
         prev_starved <= starved;
      end
   end

   sat_counter #(.CW(CW)) u_underrun_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (starved & ~prev_starved),
      .clr   (clear),
      .count (underrun_count)
   );

   sat_counter #(.CW(CW)) u_beat_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (beat),
      .clr   (clear),
      .count (beat_count)
   );

`ifdef FIFO_UNDERRUN_MON_GAP_STATS_EN
   logic [CW-1:0] gap_count;
   logic [CW-1:0] gap_next;
   logic [CW-1:0] max_q;

   sat_counter #(.CW(CW)) u_gap_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (starved),
      .clr   (clear | ~starved),
      .count (gap_count)
   );

   // Post-increment gap value, matching what the gap counter will hold next cycle.
   assign gap_next = !starved ? '0 : ((gap_count == '1) ? gap_count : gap_count + CW'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         max_q <= '0;
      else if (clear)
         max_q <= '0;
      else if (gap_next > max_q)
         max_q <= gap_next;
   end

   assign max_gap = max_q;
`else
   assign max_gap = '0;
`endif

endmodule

// File: tb/tb_fifo_underrun_mon.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_fifo_underrun_mon;

   logic         clk = 1'b0;
   logic         reset;
   logic         stream_tvalid, stream_tready, stream_tlast, clear;
   logic [511:0] stream_tdata;
   logic [7:0]   tdata8;

   logic         in_packet, underrun;
   logic [31:0]  underrun_count, beat_count, max_gap;
   logic         in_packet4, underrun4;
   logic [3:0]   underrun_count4, beat_count4, max_gap4;

   int checks = 0;
   int errors = 0;

   // Model: true (unbounded) statistics; saturation applied at comparison time.
   bit              m_in_pkt, m_prev_starved, m_underrun;
   longint unsigned m_ucount, m_beats, m_gap, m_max;

   always #5 clk = ~clk;

   fifo_underrun_mon dut (
      .clk            (clk),
      .reset          (reset),
      .stream_tvalid  (stream_tvalid),
      .stream_tready  (stream_tready),
      .stream_tdata   (stream_tdata),
      .stream_tlast   (stream_tlast),
      .clear          (clear),
      .in_packet      (in_packet),
      .underrun       (underrun),
      .underrun_count (underrun_count),
      .beat_count     (beat_count),
      .max_gap        (max_gap)
   );

   fifo_underrun_mon #(.DW(8), .CW(4)) dut4 (
      .clk            (clk),
      .reset          (reset),
      .stream_tvalid  (stream_tvalid),
      .stream_tready  (stream_tready),
      .stream_tdata   (tdata8),
      .stream_tlast   (stream_tlast),
      .clear          (clear),
      .in_packet      (in_packet4),
      .underrun       (underrun4),
      .underrun_count (underrun_count4),
      .beat_count     (beat_count4),
      .max_gap        (max_gap4)
   );

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint unsigned sat(input longint unsigned x, input int w);
      longint unsigned mx;
      mx = (64'd1 << w) - 1;
      return (x > mx) ? mx : x;
   endfunction

   function automatic longint unsigned exp_max(input int w);
`ifdef FIFO_UNDERRUN_MON_GAP_STATS_EN
      return sat(m_max, w);
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_in_pkt = 0; m_prev_starved = 0; m_underrun = 0;
      m_ucount = 0; m_beats = 0; m_gap = 0; m_max = 0;
   endtask

   task automatic model_cycle(input bit v, input bit r, input bit l, input bit c);
      bit beat, starved;
      beat    = v & r;
      starved = m_in_pkt & r & !v;
      if (c) begin
         m_underrun = 0; m_ucount = 0; m_beats = 0; m_gap = 0; m_max = 0;
      end else begin
         if (starved) m_underrun = 1;
         if (starved && !m_prev_starved) m_ucount++;
         if (beat) m_beats++;
         m_gap = starved ? m_gap + 1 : 0;
         if (m_gap > m_max) m_max = m_gap;
      end
      m_prev_starved = starved;
      if (beat) m_in_pkt = !l;
   endtask

   task automatic compare_all();
      check("in_packet",        in_packet,       m_in_pkt);
      check("underrun",         underrun,        m_underrun);
      check("underrun_count",   underrun_count,  sat(m_ucount, 32));
      check("beat_count",       beat_count,      sat(m_beats, 32));
      check("max_gap",          max_gap,         exp_max(32));
      check("w4_in_packet",     in_packet4,      m_in_pkt);
      check("w4_underrun",      underrun4,       m_underrun);
      check("w4_underrun_count", underrun_count4, sat(m_ucount, 4));
      check("w4_beat_count",    beat_count4,     sat(m_beats, 4));
      check("w4_max_gap",       max_gap4,        exp_max(4));
   endtask

   // Drive one cycle of stimulus from the negedge, update the model at the posedge, check at next negedge.
   task automatic step(input bit v, input bit r, input bit l, input bit c);
      stream_tvalid = v; stream_tready = r; stream_tlast = l; clear = c;
      stream_tdata  = {16{$urandom}};
      tdata8        = 8'($urandom);
      @(posedge clk);
      model_cycle(v, r, l, c);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      stream_tvalid = 0; stream_tready = 0; stream_tlast = 0; clear = 0;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1);
   end

   initial begin
      reset = 1'b0; stream_tvalid = 0; stream_tready = 0; stream_tlast = 0; clear = 0;
      stream_tdata = '0; tdata8 = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Clean 4-beat packet.
      for (int i = 0; i < 4; i++) step(1, 1, i == 3, 0);
      check("pkt4_beats", beat_count, 4);
      check("pkt4_underrun", underrun, 0);
      check("pkt4_in_packet", in_packet, 0);

      // Single 3-cycle gap.
      do_reset();
      step(1, 1, 0, 0);
      check("gap3_open", in_packet, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      step(1, 1, 1, 0);
      check("gap3_underrun", underrun, 1);
      check("gap3_count", underrun_count, 1);
`ifdef FIFO_UNDERRUN_MON_GAP_STATS_EN
      check("gap3_max", max_gap, 3);
`else
      check("gap3_max", max_gap, 0);
`endif

      // Starvation in IDLE does not count.
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      check("idle_starve_count", underrun_count, 1);

      // Two gaps of 2 and 5, then backpressure.
      do_reset();
      step(1, 1, 0, 0);
      for (int i = 0; i < 2; i++) step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      check("gap25_count", underrun_count, 2);
`ifdef FIFO_UNDERRUN_MON_GAP_STATS_EN
      check("gap25_max", max_gap, 5);
`endif
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
      check("bp_count", underrun_count, 2);
      check("bp_beats", beat_count, 3);
      step(1, 1, 1, 0);

      // Saturation of the 4-bit instance, then clear together with a beat.
      do_reset();
      for (int i = 0; i < 20; i++) step(1, 1, 1'($urandom_range(0, 1)), 0);
      check("sat_beats4", beat_count4, 15);
      check("sat_beats32", beat_count, 20);
      step(1, 1, 0, 1);
      check("clr_beats4", beat_count4, 0);
      check("clr_beats32", beat_count, 0);
      check("clr_keeps_state", in_packet, 1);

      // Reset in the middle of a gap.
      do_reset();
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      do_reset();
      check("rst_underrun", underrun, 0);
      check("rst_in_packet", in_packet, 0);
      step(1, 1, 0, 0);
      check("rst_restart", in_packet, 1);

      // Random traffic.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         step(1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 99) == 0));
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_underrun_mon.md
FIFO_UNDERRUN_MON -- requirements
Module: fifo_underrun_mon

Interface
REQ-001 SHALL have parameter DW, default 512: width of the monitored stream_tdata.
REQ-002 SHALL have parameter CW, default 32: width of every statistics counter.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: stream_tvalid  input  1  FIFO read-side valid (monitor only).
REQ-007 Port: stream_tready  input  1  consumer ready (monitor only).
REQ-008 Port: stream_tdata  input  DW  monitored data; SHALL be unused internally.
REQ-009 Port: stream_tlast  input  1  end-of-packet marker.
REQ-010 Port: clear  input  1  synchronous pulse that zeroes statistics.
REQ-011 Port: in_packet  output  1  high while a packet is open.
REQ-012 Port: underrun  output  1  sticky flag: consumer starved mid-packet.
REQ-013 Port: underrun_count  output  CW  number of distinct starvation gaps.
REQ-014 Port: beat_count  output  CW  number of accepted beats.
REQ-015 Port: max_gap  output  CW  longest starvation gap, in cycles.

Function
REQ-016 Beat SHALL mean stream_tvalid & stream_tready in one cycle.
REQ-017 FSM states: IDLE, IN_PKT; IDLE->IN_PKT on a beat with tlast=0; IN_PKT->IDLE on a beat with tlast=1; a one-beat packet (tlast=1 in IDLE) SHALL remain in IDLE.
REQ-018 Starved cycle SHALL mean state IN_PKT & stream_tready & !stream_tvalid; starvation in IDLE SHALL NOT count.
REQ-019 Backpressure (tvalid & !tready) SHALL NOT count as starvation.
REQ-020 underrun SHALL rise on the cycle after the first starved cycle and stay high until reset or clear.
REQ-021 underrun_count SHALL increment once per gap: on a starved cycle whose previous cycle was not starved.
REQ-022 Internal gap counter SHALL increment per starved cycle and SHALL zero on any non-starved cycle.
REQ-023 beat_count SHALL increment on every beat, in either state.
REQ-024 All outputs SHALL be registered; one-cycle latency from the stream event.
REQ-025 All counters SHALL saturate at 2^CW-1, never wrap.
REQ-026 clear SHALL zero underrun, underrun_count, beat_count, max_gap and the gap counter; FSM state SHALL be unaffected; clear SHALL win over a simultaneous increment.

Reset
REQ-027 Reset SHALL force state IDLE and every output and counter to 0, asynchronously.
REQ-028 Reset mid-packet SHALL discard the open packet; the next beat is treated as packet start.

Configuration
REQ-029 Macro FIFO_UNDERRUN_MON_GAP_STATS_EN SHALL compile in max-gap tracking.
REQ-030 With the macro: max_gap SHALL update to the gap counter value on any cycle where the post-increment gap exceeds it.
REQ-031 Without the macro: max_gap SHALL be constant 0 and no gap/max registers SHALL exist; all other behaviour unchanged.

Structure
REQ-032 Package fifo_mon_pkg SHALL hold the FSM state enum and the default CW constant.
REQ-033 One sub-module, sat_counter (CW-wide, inc/clr inputs, saturating), SHALL implement every counter.

Verification
REQ-034 4-beat packet, tvalid/tready high throughout -> beat_count=4, underrun=0, in_packet back to 0.
REQ-035 Beat 1 (tlast=0), then 3 cycles tready=1/tvalid=0, then beat with tlast=1 -> underrun=1, underrun_count=1, max_gap=3 (macro on) / 0 (macro off).
REQ-036 Two gaps of 2 and 5 cycles in one packet -> underrun_count=2, max_gap=5; 4 cycles tvalid=1/tready=0 mid-packet -> counts unchanged.
REQ-037 CW=4, 20 beats -> beat_count=15 (saturated); clear asserted with a beat -> beat_count=0 next cycle.
REQ-038 Reset mid-gap -> all outputs 0 immediately; following beat with tlast=0 -> in_packet=1.
